// File: rtl/apb_seq_pkg.sv
// apb_seq_pkg: shared states, APB add-master opcodes and the command record
package apb_seq_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_RESP} seq_state_t;
    localparam logic [1:0] ADD_NOP   = 2'b00;
    localparam logic [1:0] ADD_READ  = 2'b01;
    localparam logic [1:0] ADD_WRITE = 2'b11;
    typedef struct packed {
        logic        write;
        logic [31:0] wdata;
    } apb_cmd_t;
endpackage

// File: rtl/apb_cmd_sequencer_if.sv
// apb_cmd_sequencer_if: command, response and add-master request signals of the sequencer
interface apb_cmd_sequencer_if #(parameter int DEPTH = 4);
    logic                         cmd_valid_i;
    logic                         cmd_ready_o;
    logic                         cmd_write_i;
    logic [31:0]                  cmd_wdata_i;
    logic                         rsp_valid_o;
    logic                         rsp_ready_i;
    logic                         rsp_write_o;
    logic [31:0]                  rsp_rdata_o;
    logic [1:0]                   add_o;
    logic [31:0]                  wdata_o;
    logic                         ready_i;
    logic [31:0]                  rdata_i;
    logic                         busy_o;
    logic [$clog2(DEPTH+1)-1:0]   count_o;
    modport slave (
        input  cmd_valid_i, cmd_write_i, cmd_wdata_i, rsp_ready_i, ready_i, rdata_i,
        output cmd_ready_o, rsp_valid_o, rsp_write_o, rsp_rdata_o, add_o, wdata_o, busy_o, count_o
    );
    modport master (
        output cmd_valid_i, cmd_write_i, cmd_wdata_i, rsp_ready_i, ready_i, rdata_i,
        input  cmd_ready_o, rsp_valid_o, rsp_write_o, rsp_rdata_o, add_o, wdata_o, busy_o, count_o
    );
endinterface

// File: rtl/apb_cmd_fifo.sv
// apb_cmd_fifo: synchronous command FIFO with occupancy count, pointers wrap modulo DEPTH
module apb_cmd_fifo
    import apb_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  apb_cmd_t                     din,
    output apb_cmd_t                     dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    apb_cmd_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push_ok, pop_ok;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/apb_cmd_sequencer.sv
// apb_cmd_sequencer: buffers commands and issues them one at a time to the APB add master
module apb_cmd_sequencer
    import apb_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                pclk,
    input  logic                preset_n,
    apb_cmd_sequencer_if.slave  bus
);
    seq_state_t state, state_nx;
    apb_cmd_t in_cmd, head, cur;
    logic full, empty, pop;
    logic [31:0] rdata_q;
    assign in_cmd = {bus.cmd_write_i, bus.cmd_wdata_i};
    apb_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (pclk),
        .rst_n (preset_n),
        .push  (bus.cmd_valid_i),
        .pop   (pop),
        .din   (in_cmd),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (bus.count_o)
    );
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state   <= S_IDLE;
            cur     <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (pop) cur <= head;
            if (state == S_WAIT && bus.ready_i && cur.write) rdata_q <= '0;
            if (state == S_CAPTURE) rdata_q <= bus.rdata_i;
        end
    end
    // rdata from the master lags ready by one cycle, hence the capture state for reads
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            S_IDLE: begin
                pop      = !empty;
                state_nx = empty ? S_IDLE : S_ISSUE;
            end
            S_ISSUE:   state_nx = S_WAIT;
            S_WAIT:    state_nx = !bus.ready_i ? S_WAIT : cur.write ? S_RESP : S_CAPTURE;
            S_CAPTURE: state_nx = S_RESP;
            S_RESP:    state_nx = bus.rsp_ready_i ? S_IDLE : S_RESP;
            default:   state_nx = S_IDLE;
        endcase
    end
    assign bus.cmd_ready_o = !full;
    assign bus.add_o       = state == S_ISSUE ? (cur.write ? ADD_WRITE : ADD_READ) : ADD_NOP;
    assign bus.wdata_o     = cur.wdata;
    assign bus.rsp_valid_o = state == S_RESP;
    assign bus.rsp_write_o = state == S_RESP && cur.write;
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.busy_o      = state != S_IDLE;
endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// tb_apb_cmd_sequencer: directed stimulus against a queue-based model plus a simple add-master/slave responder
module tb_apb_cmd_sequencer;
    import apb_seq_pkg::*;
    localparam int DEPTH = 4;
    typedef struct { logic w; logic [31:0] d; logic [31:0] r; } mcmd_t;
    typedef struct { logic w; logic [31:0] d; } rsp_t;

    logic pclk = 1'b0;
    logic preset_n = 1'b0;
    logic stray = 1'b0;
    int ecnt = 0;
    int n_cmp = 0;
    int n_bad = 0;

    apb_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();
    apb_cmd_sequencer #(.DEPTH(DEPTH)) dut (.pclk(pclk), .preset_n(preset_n), .bus(bus));

    always #5 pclk = ~pclk;
    always @(posedge pclk) ecnt <= ecnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, ecnt);
        end
    endtask

    // Add master + slave: SETUP the cycle after the request, ACCESS with ready next, rdata one cycle later
    int mph = 0;
    logic [1:0] ma, mop = ADD_NOP;
    logic [31:0] mw, mem = '0;
    logic mr;
    always_comb bus.ready_i = (mph == 2) || stray;
    always_comb bus.rdata_i = (mph == 3) ? mem : ~mem;
    initial forever begin
        @(negedge pclk);
        ma = bus.add_o;
        mw = bus.wdata_o;
        mr = preset_n;
        @(posedge pclk);
        #1;
        if (!mr) begin
            mph = 0;
            mem = '0;
        end else if (mph == 0) begin
            if (ma != ADD_NOP) begin
                mph = 1;
                mop = ma;
            end
        end else if (mph == 1) begin
            mph = 2;
        end else if (mph == 2) begin
            mph = 3;
            if (mop == ADD_WRITE) mem = mw;
        end else begin
            mph = 0;
        end
    end

    // Reference model: accepted commands in order, one in flight, fixed master latency
    mcmd_t q[$];
    mcmd_t cur;
    mcmd_t nc;
    rsp_t rlog[$];
    rsp_t rr;
    logic outst = 1'b0;
    logic rst_prev = 1'b1;
    logic idle_ne = 1'b0;
    logic exp_rv = 1'b0;
    int issue_cyc = 0;
    logic [31:0] mmem = '0;
    logic [31:0] last_wd = '0;
    initial forever begin
        @(negedge pclk);
        if (rst_prev) begin
            q.delete();
            outst = 1'b0;
            mmem = '0;
            last_wd = '0;
            exp_rv = 1'b0;
            chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
            chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
            chk("rst_rsp_write", 32'(bus.rsp_write_o), 32'd0);
            chk("rst_rsp_rdata", bus.rsp_rdata_o, 32'd0);
            chk("rst_add", 32'(bus.add_o), 32'd0);
            chk("rst_wdata", bus.wdata_o, 32'd0);
            chk("rst_busy", 32'(bus.busy_o), 32'd0);
            chk("rst_count", 32'(bus.count_o), 32'd0);
        end else begin
            if (idle_ne) begin
                cur = q.pop_front();
                outst = 1'b1;
                issue_cyc = ecnt;
                last_wd = cur.d;
            end
            chk("add", 32'(bus.add_o), idle_ne ? (cur.w ? 32'd3 : 32'd1) : 32'd0);
            chk("wdata", bus.wdata_o, last_wd);
            chk("busy", 32'(bus.busy_o), 32'(outst));
            chk("count", 32'(bus.count_o), 32'(q.size()));
            chk("cmd_ready", 32'(bus.cmd_ready_o), 32'(q.size() != DEPTH));
            exp_rv = outst && (ecnt >= issue_cyc + (cur.w ? 3 : 4));
            chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(exp_rv));
            if (exp_rv) begin
                chk("rsp_write", 32'(bus.rsp_write_o), 32'(cur.w));
                chk("rsp_rdata", bus.rsp_rdata_o, cur.r);
            end
        end
        idle_ne = !outst && q.size() > 0;
        rst_prev = !preset_n;
        if (preset_n) begin
            if (bus.cmd_valid_i && q.size() != DEPTH) begin
                nc.w = bus.cmd_write_i;
                nc.d = bus.cmd_wdata_i;
                nc.r = bus.cmd_write_i ? 32'd0 : mmem;
                q.push_back(nc);
                if (bus.cmd_write_i) mmem = bus.cmd_wdata_i;
            end
            if (exp_rv && bus.rsp_ready_i) outst = 1'b0;
            if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                rr.w = bus.rsp_write_o;
                rr.d = bus.rsp_rdata_o;
                rlog.push_back(rr);
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic push(input logic w, input logic [31:0] d, output int acc);
        int n = 0;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = w;
        bus.cmd_wdata_i = d;
        @(negedge pclk);
        while (!bus.cmd_ready_o && n < 100) begin
            n++;
            @(negedge pclk);
        end
        if (n >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_accept: got no acceptance expected acceptance within 100 cycles");
        end
        acc = ecnt;
        tick();
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_n(input string nm, input int n);
        for (int i = 0; i < 400 && rlog.size() < n; i++) @(negedge pclk);
        chk(nm, 32'(rlog.size()), 32'(n));
    endtask

    logic [31:0] t3_d [6] = '{32'h12345678, 32'h0, 32'h0, 32'h22, 32'h0, 32'h33};
    logic        t3_w [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int acc, dmy, n3, nv;
        logic seen;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_write_i = 1'b0;
        bus.cmd_wdata_i = '0;
        bus.rsp_ready_i = 1'b1;
        tick();
        tick();
        preset_n = 1'b1;
        tick();

        // single write: one-cycle issue, response five cycles after acceptance
        rlog.delete();
        push(1'b1, 32'hDEADBEEF, acc);
        n3 = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge pclk);
            if (bus.add_o == ADD_WRITE) begin
                n3++;
                chk("t1_issue_wdata", bus.wdata_o, 32'hDEADBEEF);
            end
            if (bus.rsp_valid_o) begin
                seen = 1'b1;
                chk("t1_rsp_cycle", 32'(ecnt - acc), 32'd5);
                chk("t1_rsp_write", 32'(bus.rsp_write_o), 32'd1);
                chk("t1_rsp_rdata", bus.rsp_rdata_o, 32'd0);
            end
        end
        chk("t1_rsp_seen", 32'(seen), 32'd1);
        chk("t1_issue_cycles", 32'(n3), 32'd1);
        repeat (3) tick();

        // write then read back
        rlog.delete();
        push(1'b1, 32'h12345678, dmy);
        push(1'b0, 32'hCAFE0001, dmy);
        wait_n("t2_rsp_count", 2);
        if (rlog.size() >= 2) begin
            chk("t2_first_write", 32'(rlog[0].w), 32'd1);
            chk("t2_first_rdata", rlog[0].d, 32'd0);
            chk("t2_second_write", 32'(rlog[1].w), 32'd0);
            chk("t2_second_rdata", rlog[1].d, 32'h12345678);
        end
        repeat (3) tick();

        // stalled consumer: fill FIFO, hold response for 10 cycles, then drain in order
        rlog.delete();
        bus.rsp_ready_i = 1'b0;
        push(1'b0, 32'h0, dmy);
        push(1'b1, 32'h11, dmy);
        push(1'b1, 32'h22, dmy);
        push(1'b0, 32'h0, dmy);
        push(1'b1, 32'h33, dmy);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b0;
        bus.cmd_wdata_i = 32'h0;
        @(negedge pclk);
        chk("t3_full_ready", 32'(bus.cmd_ready_o), 32'd0);
        chk("t3_full_count", 32'(bus.count_o), 32'd4);
        for (int i = 0; i < 30 && !bus.rsp_valid_o; i++) @(negedge pclk);
        chk("t3_rsp_seen", 32'(bus.rsp_valid_o), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            stray = (i == 4);
            @(negedge pclk);
            chk("t3_hold_valid", 32'(bus.rsp_valid_o), 32'd1);
            chk("t3_hold_rdata", bus.rsp_rdata_o, 32'h12345678);
            chk("t3_hold_add", 32'(bus.add_o), 32'd0);
            chk("t3_hold_ready", 32'(bus.cmd_ready_o), 32'd0);
        end
        tick();
        stray = 1'b0;
        bus.rsp_ready_i = 1'b1;
        push(1'b0, 32'h0, dmy);
        wait_n("t3_rsp_count", 6);
        for (int i = 0; i < 6; i++) begin
            if (i < rlog.size()) begin
                chk($sformatf("t3_rsp%0d_write", i), 32'(rlog[i].w), 32'(t3_w[i]));
                chk($sformatf("t3_rsp%0d_rdata", i), rlog[i].d, t3_d[i]);
            end
        end
        repeat (3) tick();

        // pointer wrap: ten writes then a read
        rlog.delete();
        for (int v = 1; v <= 10; v++) push(1'b1, 32'(v), dmy);
        push(1'b0, 32'h0, dmy);
        wait_n("t5_rsp_count", 11);
        if (rlog.size() >= 11) begin
            chk("t5_read_write", 32'(rlog[10].w), 32'd0);
            chk("t5_read_rdata", rlog[10].d, 32'hA);
        end
        for (int i = 0; i < 20 && (bus.busy_o || bus.count_o != 0); i++) @(negedge pclk);
        chk("t5_final_count", 32'(bus.count_o), 32'd0);
        chk("t5_final_busy", 32'(bus.busy_o), 32'd0);
        tick();

        // reset while waiting on the master with two commands queued
        rlog.delete();
        push(1'b0, 32'h0, dmy);
        push(1'b1, 32'h55, dmy);
        push(1'b1, 32'h66, dmy);
        preset_n = 1'b0;
        @(negedge pclk);
        chk("t6_pre_count", 32'(bus.count_o), 32'd2);
        chk("t6_pre_busy", 32'(bus.busy_o), 32'd1);
        tick();
        preset_n = 1'b1;
        @(negedge pclk);
        chk("t6_post_count", 32'(bus.count_o), 32'd0);
        chk("t6_post_busy", 32'(bus.busy_o), 32'd0);
        chk("t6_post_add", 32'(bus.add_o), 32'd0);
        chk("t6_post_ready", 32'(bus.cmd_ready_o), 32'd1);
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge pclk);
            if (bus.rsp_valid_o) nv++;
        end
        chk("t6_no_rsp_cycles", 32'(nv), 32'd0);
        chk("t6_no_rsp_log", 32'(rlog.size()), 32'd0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected end within 20000 cycles");
        $fatal(1, "watchdog expired");
    end
endmodule
